// File: rtl/rx_response_collector.sv
// Collects switch read responses: one tracking slot per switch, round-robin
// arbitration of completed slots into a show-ahead response FIFO.
module rx_response_collector #(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SW_INST-1:0]         sel_en,
  input  logic                           wr_rd_s,
  input  logic [7:0]                     op_id,
  input  logic [NUM_SW_INST-1:0]         rd_valid,
  input  logic [NUM_SW_INST*W_WIDTH-1:0] rd_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [16+W_WIDTH:0]            rsp_frame,
  output logic [NUM_SW_INST-1:0]         pending,
  output logic                           proto_err
);

  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int PW    = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int FW    = 17 + W_WIDTH;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} slot_state_t;

  logic                            w_multi_sel;
  logic [NUM_SW_INST-1:0]          w_issue;
  logic [NUM_SW_INST-1:0]          w_ready;
  logic [NUM_SW_INST-1:0]          w_viol;
  logic [NUM_SW_INST-1:0][FW-1:0]  w_slot_frame;
  logic                            w_grant_valid;
  logic [PW-1:0]                   w_grant_idx;
  logic [FW-1:0]                   w_push_frame;
  logic                            w_push;
  logic                            w_pop;

  logic [PW-1:0]                   r_rr_ptr;
  logic [AW-1:0]                   r_wr_ptr;
  logic [AW-1:0]                   r_rd_ptr;
  logic [CW-1:0]                   r_count;
  logic                            r_proto_err;
  logic [FW-1:0]                   r_mem [FIFO_DEPTH];

  // A multi-hot strobe is dropped entirely; writes never allocate a slot.
  assign w_multi_sel = |(sel_en & (sel_en - 1'b1));
  assign w_issue     = sel_en & {NUM_SW_INST{~wr_rd_s & ~w_multi_sel}};

  for (genvar gi = 0; gi < NUM_SW_INST; gi++) begin : g_slot
    slot_state_t         r_state;
    logic [TW-1:0]       r_timer;
    logic [7:0]          r_op_id;
    logic [W_WIDTH-1:0]  r_data;
    logic                r_err;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_timer <= '0;
        r_op_id <= '0;
        r_data  <= '0;
        r_err   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_issue[gi]) begin
              r_state <= S_WAIT;
              r_op_id <= op_id;
              r_timer <= '0;
            end
          end
          S_WAIT: begin
            r_timer <= r_timer + 1'b1;
            // A return on the timeout cycle still counts as a good response.
            if (rd_valid[gi]) begin
              r_state <= S_READY;
              r_data  <= rd_data[gi*W_WIDTH +: W_WIDTH];
              r_err   <= 1'b0;
            end else if (r_timer == TIMER_LAST) begin
              r_state <= S_READY;
              r_data  <= '0;
              r_err   <= 1'b1;
            end
          end
          S_READY: begin
            if (w_push && (w_grant_idx == PW'(gi))) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    assign w_ready[gi]      = (r_state == S_READY);
    assign pending[gi]      = (r_state != S_IDLE);
    assign w_slot_frame[gi] = {r_err, r_op_id, 8'(gi), r_data};
    assign w_viol[gi]       = (w_issue[gi] && (r_state != S_IDLE)) ||
                              (rd_valid[gi] && (r_state != S_WAIT));
  end

  // Scan from the highest offset down so the slot nearest rr_ptr wins.
  always_comb begin
    logic [PW:0]   v_sum;
    logic [PW-1:0] v_pick;
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_push_frame  = '0;
    v_sum         = '0;
    v_pick        = '0;
    for (int k = NUM_SW_INST - 1; k >= 0; k--) begin
      v_sum = {1'b0, r_rr_ptr} + (PW + 1)'(k);
      if (v_sum >= (PW + 1)'(NUM_SW_INST)) begin
        v_sum = v_sum - (PW + 1)'(NUM_SW_INST);
      end
      v_pick = v_sum[PW-1:0];
      if (w_ready[v_pick]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = v_pick;
        w_push_frame  = w_slot_frame[v_pick];
      end
    end
  end

  // A full FIFO blocks the push even when the head pops in the same cycle.
  assign w_push = w_grant_valid && (r_count < CW'(FIFO_DEPTH));
  assign w_pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= (w_grant_idx == PW'(NUM_SW_INST - 1)) ? '0 : w_grant_idx + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_multi_sel || (|w_viol)) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_frame;
    end
  end

  assign rsp_valid = (r_count != '0);
  assign rsp_frame = rsp_valid ? r_mem[r_rd_ptr] : '0;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_rx_response_collector.sv
// Directed bench: stimulus pushes expected frames to a queue, a monitor pops
// and compares on every accepted response.
module tb_rx_response_collector;

  logic         clk;
  logic         rst;
  logic [4:0]   sel_en;
  logic         wr_rd_s;
  logic [7:0]   op_id;
  logic [4:0]   rd_valid;
  logic [39:0]  rd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [24:0]  rsp_frame;
  logic [4:0]   pending;
  logic         proto_err;

  int tests_run = 0;
  int tests_failed = 0;
  int n_frames = 0;
  int n_expected = 0;
  logic [24:0] exp_q[$];

  rx_response_collector #(
    .NUM_SW_INST(5), .W_WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .sel_en(sel_en), .wr_rd_s(wr_rd_s), .op_id(op_id),
    .rd_valid(rd_valid), .rd_data(rd_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_frame(rsp_frame), .pending(pending),
    .proto_err(proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] mkf(input logic err, input logic [7:0] op,
                                      input logic [7:0] idx, input logic [7:0] d);
    return {err, op, idx, d};
  endfunction

  task automatic expect_frame(input logic [24:0] f);
    exp_q.push_back(f);
    n_expected++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int slot, input logic [7:0] op, input logic wr);
    sel_en  = 5'(1 << slot);
    wr_rd_s = wr;
    op_id   = op;
    tick();
    sel_en  = '0;
    wr_rd_s = 1'b0;
  endtask

  task automatic ret(input logic [4:0] mask);
    rd_valid = mask;
    tick();
    rd_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: compares every accepted frame and checks head stability under stall.
  initial begin
    logic        prev_hold;
    logic [24:0] prev_frame;
    logic [24:0] e;
    prev_hold  = 1'b0;
    prev_frame = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold && rsp_valid) chk("hold_stable", rsp_frame, prev_frame);
        if (rsp_valid && rsp_ready) begin
          n_frames++;
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", rsp_frame, 25'h0);
            if (rsp_frame == 25'h0) begin
              tests_failed++;
              $display("FAIL unexpected_frame: got %0h, expected none", rsp_frame);
            end
          end else begin
            e = exp_q.pop_front();
            chk("frame", rsp_frame, e);
            $display("[TB] frame %07h expected %07h", rsp_frame, e);
          end
        end
        prev_hold  = rsp_valid && !rsp_ready;
        prev_frame = rsp_frame;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sel_en = '0; wr_rd_s = 1'b0; op_id = '0;
    rd_valid = '0; rd_data = '0; rsp_ready = 1'b1;
    #2;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_frame", rsp_frame, 0);
    chk("rst_pending", pending, 0);
    chk("rst_proto", proto_err, 0);
    tick();
    tick();
    rst = 1'b0;

    // Single read: issue at E0, rd_valid sampled at E4, push at E5.
    issue(2, 8'h3C, 1'b0);
    chk("single_pending", pending, 5'b00100);
    repeat (3) tick();
    rd_data[2*8 +: 8] = 8'hA5;
    expect_frame(mkf(1'b0, 8'h3C, 8'h02, 8'hA5));
    ret(5'b00100);
    chk("single_lat1_valid", rsp_valid, 0);
    chk("single_lat1_pend", pending[2], 1);
    tick();
    chk("single_lat2_valid", rsp_valid, 1);
    chk("single_pend_fall", pending, 0);
    tick();
    chk("single_drained", rsp_valid, 0);

    // Write filtering.
    issue(0, 8'h99, 1'b1);
    chk("write_pending", pending, 0);
    repeat (3) tick();
    chk("write_valid", rsp_valid, 0);
    chk("write_proto", proto_err, 0);

    // Simultaneous returns from rr_ptr = 0.
    do_reset();
    issue(0, 8'h01, 1'b0);
    issue(1, 8'h02, 1'b0);
    issue(4, 8'h03, 1'b0);
    rd_data[0*8 +: 8] = 8'h11;
    rd_data[1*8 +: 8] = 8'h22;
    rd_data[4*8 +: 8] = 8'h44;
    expect_frame(mkf(1'b0, 8'h01, 8'h00, 8'h11));
    expect_frame(mkf(1'b0, 8'h02, 8'h01, 8'h22));
    expect_frame(mkf(1'b0, 8'h03, 8'h04, 8'h44));
    ret(5'b10011);
    chk("simul_ready_pend", pending, 5'b10011);
    tick();
    chk("simul_c1_valid", rsp_valid, 1);
    chk("simul_c1_pend", pending, 5'b10010);
    tick();
    chk("simul_c2_valid", rsp_valid, 1);
    chk("simul_c2_pend", pending, 5'b10000);
    tick();
    chk("simul_c3_valid", rsp_valid, 1);
    chk("simul_c3_pend", pending, 5'b00000);
    tick();
    chk("simul_done", rsp_valid, 0);

    // Backpressure: five completions into a 4-deep FIFO; order 0..4 needs rr_ptr back at 0.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) issue(i, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      rd_data[i*8 +: 8] = 8'(8'hB0 + i);
      expect_frame(mkf(1'b0, 8'(8'h20 + i), 8'(i), 8'(8'hB0 + i)));
    end
    ret(5'b11111);
    repeat (6) tick();
    chk("bp_fifth_pending", pending, 5'b10000);
    chk("bp_valid", rsp_valid, 1);
    chk("bp_head", rsp_frame, mkf(1'b0, 8'h20, 8'h00, 8'hB0));
    rsp_ready = 1'b1;
    repeat (7) tick();
    chk("bp_drained_valid", rsp_valid, 0);
    chk("bp_drained_pend", pending, 0);

    // Timeout: issue at E0, error frame pushed at E9.
    issue(3, 8'h77, 1'b0);
    repeat (7) tick();
    tick();
    chk("to_e8_valid", rsp_valid, 0);
    chk("to_e8_pend", pending, 5'b01000);
    expect_frame(mkf(1'b1, 8'h77, 8'h03, 8'h00));
    tick();
    chk("to_e9_valid", rsp_valid, 1);
    chk("to_e9_pend", pending, 0);
    tick();

    // rd_valid on the timeout cycle wins.
    issue(3, 8'h77, 1'b0);
    repeat (7) tick();
    rd_data[3*8 +: 8] = 8'h5A;
    ret(5'b01000);
    chk("toedge_e8_valid", rsp_valid, 0);
    expect_frame(mkf(1'b0, 8'h77, 8'h03, 8'h5A));
    tick();
    chk("toedge_e9_valid", rsp_valid, 1);
    tick();
    chk("no_proto_so_far", proto_err, 0);

    // Violations.
    ret(5'b00010);
    chk("viol_rdv_idle", proto_err, 1);
    chk("viol_rdv_pend", pending, 0);
    repeat (2) tick();
    chk("viol_rdv_noframe", rsp_valid, 0);
    do_reset();
    chk("viol_cleared", proto_err, 0);
    sel_en = 5'b00011; wr_rd_s = 1'b0; op_id = 8'hEE;
    tick();
    sel_en = '0;
    chk("viol_multi_pend", pending, 0);
    chk("viol_multi_proto", proto_err, 1);
    do_reset();
    issue(1, 8'hA1, 1'b0);
    issue(1, 8'hB2, 1'b0);
    chk("viol_busy_proto", proto_err, 1);
    chk("viol_busy_pend", pending, 5'b00010);
    rd_data[1*8 +: 8] = 8'h33;
    expect_frame(mkf(1'b0, 8'hA1, 8'h01, 8'h33));
    ret(5'b00010);
    repeat (3) tick();
    chk("viol_busy_done", rsp_valid, 0);

    // Asynchronous reset mid-operation discards everything.
    do_reset();
    rsp_ready = 1'b0;
    issue(2, 8'h55, 1'b0);
    rd_data[2*8 +: 8] = 8'hC3;
    ret(5'b00100);
    tick();
    issue(1, 8'h66, 1'b0);
    ret(5'b01000);
    chk("pre_rst_valid", rsp_valid, 1);
    chk("pre_rst_pend", pending, 5'b00010);
    chk("pre_rst_proto", proto_err, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_frame", rsp_frame, 0);
    chk("arst_pend", pending, 0);
    chk("arst_proto", proto_err, 0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (12) tick();
    chk("post_rst_valid", rsp_valid, 0);
    chk("post_rst_pend", pending, 0);

    chk("queue_empty", exp_q.size(), 0);
    chk("frame_count", n_frames, n_expected);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
